// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int P0 = 0;
  localparam int P1 = 1;

endpackage

// File: rtl/sram_arb_if.sv
// Requester-side bundle for both arbiter ports. Handshake: a port holds reqN
// until it sees gntN high before a rising edge; that edge consumes the request.
interface sram_arb_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  req0, req1;
  logic                  wr0, wr1;
  logic                  lock0, lock1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] din0, din1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, wr0, wr1, lock0, lock1, addr0, addr1, din0, din1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, wr0, wr1, lock0, lock1, addr0, addr1, din0, din1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/sp_sram.sv
// Behavioural single-port SRAM with registered read data; qout is undefined after a write.
module sp_sram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  output logic [DATA_WIDTH-1:0] qout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[addr] <= din;
      qout      <= 'x;
    end else begin
      qout <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_arb_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/sram_arb.sv
// Round-robin arbiter with burst locking in front of a single-port SRAM;
// read data returns on rvalidN one cycle after the read grant.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_arb_if.slave             bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_wr,
  input  logic [DATA_WIDTH-1:0] sram_qout,
  output state_t                dbg_state
);

  state_t     state, state_next;
  logic       prio;
  logic       rpend0, rpend1;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;

  rr_pick2 u_pick (
    .req  ({bus.req1, bus.req0}),
    .prio (prio),
    .gnt  (pick_gnt)
  );

  // State register plus the prio pointer and read-pending flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      prio   <= 1'b0;
      rpend0 <= 1'b0;
      rpend1 <= 1'b0;
    end else begin
      state  <= state_next;
      if (gnt[P0]) prio <= 1'b1;
      else if (gnt[P1]) prio <= 1'b0;
      rpend0 <= gnt[P0] & ~bus.wr0;
      rpend1 <= gnt[P1] & ~bus.wr1;
    end
  end

  // Ownership follows the grant: a locked grant keeps it, anything else drops to IDLE.
  always_comb begin
    state_next = IDLE;
    if (gnt[P0] && bus.lock0) state_next = OWN0;
    else if (gnt[P1] && bus.lock1) state_next = OWN1;
  end

  // An owner that stops requesting falls back to the picker in the same cycle.
  always_comb begin
    gnt = pick_gnt;
    unique case (state)
      OWN0:    if (bus.req0) gnt = 2'b01;
      OWN1:    if (bus.req1) gnt = 2'b10;
      default: ;
    endcase
    if (rst) gnt = 2'b00;
  end

  always_comb begin
    sram_wr   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (gnt[P0]) begin
      sram_wr   = bus.wr0;
      sram_addr = bus.addr0;
      sram_din  = bus.din0;
    end else if (gnt[P1]) begin
      sram_wr   = bus.wr1;
      sram_addr = bus.addr1;
      sram_din  = bus.din1;
    end
  end

  assign bus.gnt0    = gnt[P0];
  assign bus.gnt1    = gnt[P1];
  assign bus.rvalid0 = rpend0;
  assign bus.rvalid1 = rpend1;
  assign bus.rdata0  = sram_qout;
  assign bus.rdata1  = sram_qout;
  assign dbg_state   = state;

endmodule

// File: tb/tb_sram_arb.sv
// Directed and random checks of sram_arb against a rule-level reference model.
module tb_sram_arb;
  import sram_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic          sram_wr;
  logic [DW-1:0] sram_qout;
  state_t        dbg_state;

  sram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_wr   (sram_wr),
    .sram_qout (sram_qout),
    .dbg_state (dbg_state)
  );

  sp_sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_sram (
    .clk  (clk),
    .addr (sram_addr),
    .din  (sram_din),
    .wr   (sram_wr),
    .qout (sram_qout)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: owner is -1 when nobody holds a lock
  int            n_assert = 0;
  int            n_fail   = 0;
  int            owner    = -1;
  int            prio_m   = 0;
  bit            pend [2] = '{1'b0, 1'b0};
  logic [DW-1:0] mem_m [16];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic state_t exp_state();
    if (owner == 0) return OWN0;
    if (owner == 1) return OWN1;
    return IDLE;
  endfunction

  task automatic model_reset();
    owner  = -1;
    prio_m = 0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // driver: apply one cycle of requests, check, clock, advance the model
  task automatic step(input bit r0, input bit w0, input bit l0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0,
                      input bit r1, input bit w1, input bit l1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1);
    bit            rq [2];
    bit            wq [2];
    bit            lq [2];
    logic [AW-1:0] aq [2];
    logic [DW-1:0] dq [2];
    int            g;
    rq = '{r0, r1}; wq = '{w0, w1}; lq = '{l0, l1}; aq = '{a0, a1}; dq = '{d0, d1};
    bus.req0 = r0; bus.wr0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.din0 = d0;
    bus.req1 = r1; bus.wr1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.din1 = d1;
    #1;
    g = -1;
    if (owner >= 0 && rq[owner]) g = owner;
    else if (r0 && r1) g = prio_m;
    else if (r0) g = 0;
    else if (r1) g = 1;
    chk("gnt0", 32'(bus.gnt0), 32'(g == 0));
    chk("gnt1", 32'(bus.gnt1), 32'(g == 1));
    chk("sram_wr", 32'(sram_wr), (g >= 0) ? 32'(wq[g]) : 32'd0);
    chk("sram_addr", 32'(sram_addr), (g >= 0) ? 32'(aq[g]) : 32'd0);
    chk("sram_din", 32'(sram_din), (g >= 0) ? 32'(dq[g]) : 32'd0);
    chk("rvalid0", 32'(bus.rvalid0), 32'(pend[0]));
    chk("rvalid1", 32'(bus.rvalid1), 32'(pend[1]));
    if (pend[0] && exp_q0.size() > 0) chk("rdata0", 32'(bus.rdata0), 32'(exp_q0.pop_front()));
    if (pend[1] && exp_q1.size() > 0) chk("rdata1", 32'(bus.rdata1), 32'(exp_q1.pop_front()));
    chk("state", 32'(dbg_state), 32'(exp_state()));
    @(posedge clk);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    if (g >= 0) begin
      if (wq[g]) mem_m[aq[g]] = dq[g];
      else begin
        pend[g] = 1'b1;
        if (g == 0) exp_q0.push_back(mem_m[aq[g]]);
        else        exp_q1.push_back(mem_m[aq[g]]);
      end
      owner  = lq[g] ? g : -1;
      prio_m = 1 - g;
    end else begin
      owner = -1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.lock0 = 1'b0; bus.addr0 = '0; bus.din0 = '0;
    bus.req1 = 1'b1; bus.wr1 = 1'b1; bus.lock1 = 1'b0; bus.addr1 = '0; bus.din1 = '0;

    // reset state, with both ports requesting writes
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_sram_wr", 32'(sram_wr), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // preload every address so random reads have a known value
    for (int i = 0; i < 16; i++) step(1, 1, 0, 4'(i), 16'($urandom), 0, 0, 0, 0, 0);

    // write then read, port 0
    step(1, 1, 0, 4'd3, 16'hBEEF, 0, 0, 0, 0, 0);
    step(1, 0, 0, 4'd3, 16'h0000, 0, 0, 0, 0, 0);
    idle();

    // contention round-robin on preloaded reads
    step(1, 1, 0, 4'd1, 16'h0011, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 4'd2, 16'h0022);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd1, 0, 1, 0, 0, 4'd2, 0);
    idle();

    // lock burst by port 1 while port 0 keeps requesting
    step(1, 0, 0, 4'd9, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'd5, 0, 1, 0, (i < 3), 4'(i), 0);
    step(1, 0, 0, 4'd5, 0, 0, 0, 0, 0, 0);
    idle();

    // owner drops its request while the other port waits
    step(1, 0, 1, 4'd4, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 4'd6, 0, 1, 0, 0, 4'd8, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 4'd8, 0);
    idle();

    // reset with a read pending; prio was left pointing at port 1
    step(1, 0, 0, 4'd5, 0, 0, 0, 0, 0, 0);
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 4'd5; bus.din0 = 16'hDEAD;
    bus.req1 = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rstmid_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rstmid_sram_wr", 32'(sram_wr), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_rvalid0_held", 32'(bus.rvalid0), 32'd0);
    rst = 1'b0;
    step(1, 0, 0, 4'd5, 0, 1, 0, 0, 4'd6, 0);
    step(1, 0, 0, 4'd5, 0, 1, 0, 0, 4'd6, 0);
    idle();

    // write on port 1 returns nothing, then read it back
    step(0, 0, 0, 0, 0, 1, 1, 0, 4'd7, 16'h1234);
    step(0, 0, 0, 0, 0, 1, 0, 0, 4'd7, 0);
    idle();

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), 16'($urandom),
           $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)), 16'($urandom));
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arb.md
# sram_arb

Two-port arbiter and sequencer for the single-port behavioural SRAM in the FIR datapath. It lets two requesters share one SRAM macro: port 0 is the sample/coefficient loader and port 1 is the FIR tap-read sequencer. Each cycle it grants at most one request using round-robin priority, with optional burst locking. It returns read data with a per-port valid strobe one cycle after the grant.

## Interface
- ADDR_WIDTH, 4, SRAM address width
- DATA_WIDTH, 16, SRAM data width
- clk  in  1  rising-edge clock shared with the SRAM
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request valid, held until granted
- wr0 / wr1  in  1  1 = write, 0 = read
- lock0 / lock1  in  1  keep ownership after this grant
- addr0 / addr1  in  ADDR_WIDTH  request address
- din0 / din1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  combinational grant; the request is consumed on this edge
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a read grant
- rdata0 / rdata1  out  DATA_WIDTH  read data, equal to sram_qout
- sram_addr  out  ADDR_WIDTH  to the SRAM addr port
- sram_din  out  DATA_WIDTH  to the SRAM din port
- sram_wr  out  1  to the SRAM wr port
- sram_qout  in  DATA_WIDTH  from the SRAM qout port

## Operation
- **FSM states**
  - IDLE: no owner; round-robin arbitration.
  - OWN0 / OWN1: the locked port has absolute priority.
- **IDLE arbitration**
  - If only one port requests, that port is granted.
  - If both request, the port selected by the `prio` register is granted.
  - After any grant, `prio` points to the other port.
- **Entering ownership:** a grant with lock_i=1 moves the FSM to OWNi.
- **OWNi behaviour**
  - If req_i=1, port i is granted; the other port is held with gnt=0.
  - A grant with lock_i=0 returns the FSM to IDLE; `prio` points to the other port.
  - If req_i=0 in OWNi, the FSM returns to IDLE in the same cycle and the other port may be granted combinationally.
- **SRAM muxing**
  - On a grant: sram_addr/sram_din/sram_wr come from the granted port.
  - No grant: sram_wr=0, sram_addr=0, sram_din=0.
  - sram_wr is never 1 without a grant.
- **Read return**
  - A read grant sets the registered flag `rpend_i`.
  - The next cycle, rvalid_i=1 and rdata_i=sram_qout.
  - rdata is don't-care when rvalid=0.
  - Write grants never raise rvalid; the SRAM drives X on qout after a write.
- **Simultaneous events**
  - A requester may issue back-to-back reads; rvalid then stays high on consecutive cycles.
  - Grant and rvalid for the same port may be high in the same cycle (new request plus previous return).
- **Reset (asynchronous, any time, including mid-burst or with a read pending)**
  - FSM=IDLE, prio=0, rpend0=rpend1=0.
  - Therefore rvalid0=rvalid1=0.
  - gnt0=gnt1=0 and sram_wr=0 while rst=1.
  - No rvalid is ever emitted for a read granted before reset.

## Timing
- Grant is combinational from req/lock/state/prio; the SRAM samples the request on the same rising edge.
- Read latency: rvalid_i at edge N+1 for a grant at edge N, matching the registered SRAM qout.
- Write latency: 0 cycles; the data is in the array after edge N.
- Throughput: one access per cycle in aggregate.
- Worst-case wait for an unlocked contending port is 1 cycle; under a lock, the wait is bounded by the owner's burst length.

## Structure
- Shared package `sram_arb_pkg`:
  - FSM state enum {IDLE, OWN0, OWN1}.
  - Port index constants P0=0, P1=1.
- Natural sub-module `rr_pick2`: combinational 2-way round-robin picker (req[1:0], prio → gnt[1:0], onehot).
- Top level holds the FSM, the prio register, the rpend flags and the SRAM mux.
- Bench instantiates sram_arb with the existing sp_sram (ADDR_WIDTH=4, DATA_WIDTH=16).

## Test plan
1. **Write then read, port 0:**
   - Stimulus: write addr 3 = 0xBEEF, then read addr 3.
   - Response: gnt0 both cycles; rvalid0=1 with rdata0=0xBEEF exactly one cycle after the read grant; rvalid1 stays 0.
2. **Contention round-robin:**
   - Stimulus: both ports hold read requests for 4 cycles (addr0=1, addr1=2, preloaded 0x0011/0x0022).
   - Response: grants alternate P0, P1, P0, P1; rdata alternates 0x0011/0x0022 with matching rvalid.
3. **Lock burst:**
   - Stimulus: port 1 reads addrs 0..3 with lock1=1 on the first three and lock1=0 on the last; port 0 requests throughout.
   - Response: gnt0=0 for 4 cycles, then gnt0=1; FSM goes IDLE→OWN1→IDLE.
4. **Owner drops request:**
   - Stimulus: in OWN0, req0 falls while req1=1.
   - Response: gnt1=1 in that same cycle; FSM ends in IDLE.
5. **Reset mid-read:**
   - Stimulus: read granted at edge N; rst asserted before edge N+1.
   - Response: rvalid0 goes 0 immediately and stays 0 after release; next grant follows prio=0.
6. **Write does not return data:**
   - Stimulus: port 1 writes addr 7 = 0x1234.
   - Response: rvalid1=0 on the next cycle; a read of addr 7 then returns 0x1234.
